decode_issue_ctrl: RTL
======================

Name: decode_issue_ctrl

Overview:
- Decode-stage instruction buffer and issue scheduler between fetch and the two decoder instances.
- Accepts up to two fetch packets per cycle (each {exception[6:0], pc_next, pc, inst} = 103 bits) and stores them in program order.
- Presents the oldest one or two packets to decoder slot 0/1 and decides the issue group size from downstream ready and the decoders' single-issue feedback.
- Handles pipeline flush.

Parameters:
- DEPTH, 8, buffer entries; power of two, ≥4.
- PKT_W, 103, fetch packet width.
- PTR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  discard all buffered and incoming packets.
- in_valid  input  2  fetch packet valid per slot; slot0 older; 2'b10 illegal.
- in_pkt  input  2*PKT_W  slot0 in [PKT_W-1:0], slot1 above.
- in_ready  output  1  buffer can take two packets this cycle.
- out_valid  output  2  issue group valid; out_valid[1] implies out_valid[0].
- out_pkt  output  2*PKT_W  oldest (slot0) and next-oldest (slot1) entries to decoders.
- dec_single  input  2  from decoders, combinational on out_pkt: slot must issue alone.
- out_ready  input  1  downstream accepts the presented group.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- State: rd_ptr, wr_ptr (PTR_W bits, wrap modulo DEPTH), cnt (PTR_W+1 bits), storage array DEPTH×PKT_W. Storage is not reset.
- Reset (rst=1 at posedge): rd_ptr=wr_ptr=cnt=0. Resulting outputs: out_valid=0, in_ready=1, count=0. Reset overrides flush and all handshakes.
- in_ready = (DEPTH - cnt ≥ 2). Combinational from registered cnt only; no dependence on out_ready.
- Push, on clk when in_ready & !flush:
  - n_push = popcount(in_valid).
  - Slot0 packet is written at wr_ptr; slot1 at wr_ptr+1 (mod DEPTH).
  - wr_ptr += n_push.
- in_valid=2'b10 is a protocol error: the slot1 packet is ignored and n_push=0. This condition carries a simulation assertion.
- in_valid while !in_ready is dropped. Fetch must hold the packet.
- Head view (combinational):
  - out_pkt slot0 = mem[rd_ptr]; slot1 = mem[rd_ptr+1 mod DEPTH].
  - Slot1 data is don't-care when cnt<2.
- Issue grouping:
  - v0 = (cnt≥1) & !flush.
  - v1 = v0 & (cnt≥2) & !dec_single[0] & !dec_single[1].
  - out_valid = {v1, v0}.
  - The decoder asserts dec_single for CSR, TLB, IDLE, ERET, BAR, CACHE, syscall/break, invalid instruction, or nonzero exception field.
  - No combinational path from out_ready to out_valid.
- Pop, on clk when out_ready & !flush:
  - n_pop = v1 ? 2 : v0 ? 1 : 0.
  - rd_ptr += n_pop.
- Counter update: cnt_next = cnt + n_push - n_pop. Simultaneous push and pop in one cycle is legal at any occupancy that allows each individually.
- Full and empty:
  - cnt=DEPTH-1 or DEPTH: in_ready=0, pops continue normally.
  - cnt=0: out_valid=0 and push proceeds. There is no bypass; a packet written at cycle t is presentable at t+1 (1-cycle latency).
- Flush (flush=1 at posedge):
  - Next state rd_ptr=wr_ptr=cnt=0.
  - Any same-cycle push and pop are cancelled.
  - out_valid is forced 0 during the flush cycle.
  - in_ready is unaffected that cycle, but accepted data is discarded.
- Wrap-around: pointers wrap naturally. A two-entry push or pop straddling index DEPTH-1→0 is handled by the mod-DEPTH addressing.
- Assertions:
  - cnt ≤ DEPTH.
  - No push when !in_ready (data dropped, flagged only in simulation when in_valid held and in_ready=0 is fine).
  - out_valid[1] → out_valid[0].

Decomposition:
- Shared header (next to uop.vh): FETCH_PKT_W=103 and packet field offsets (INST 31:0, PC 63:32, PC_NEXT 95:64, EXCP 102:96).
- One sub-module, ibuf_regfile: DEPTH×PKT_W array with 2 write ports (wr_ptr, wr_ptr+1) and 2 async read ports (rd_ptr, rd_ptr+1). Pointer, count and grouping logic stay in decode_issue_ctrl.

Test Plan:
1. Reset then idle:
   - Assert rst 2 cycles → out_valid=00, in_ready=1, count=0.
   - Push slot0 pc=0x1c000000 → next cycle out_valid=01, out_pkt slot0 pc=0x1c000000.
2. Dual issue:
   - Push two packets (pc 0x1c000000, 0x1c000004), dec_single=00, out_ready=1 → next cycle out_valid=11.
   - Following cycle count=0.
3. Single-issue split:
   - Buffer holds a CSR op then an add; decoder drives dec_single=01.
   - → out_valid=01; after pop, add presented alone, out_valid=01; two cycles total.
4. Full and wrap, DEPTH=8:
   - Push 2/cycle with out_ready=0 → in_ready drops when count=7 or 8.
   - Then pop 2 and push 2 concurrently across index 7→0 → order preserved and count stays constant.
5. Flush mid-stream:
   - count=5, assert flush with in_valid=11 and out_ready=1 → out_valid=00 that cycle.
   - Next cycle count=0, out_valid=00, and no packet from the flush cycle appears.
6. Stall hold:
   - count=3, out_ready=0 for 4 cycles → out_pkt stable and count=3.
   - Illegal in_valid=10 → count unchanged and assertion fires.

Source files
------------

// File: rtl/decode_issue_ctrl_pkg.sv
// Shared fetch-packet layout and small helpers for the decode-stage instruction buffer.
package decode_issue_ctrl_pkg;

  localparam int FETCH_PKT_W     = 103;
  localparam int PKT_INST_LSB    = 0;
  localparam int PKT_INST_MSB    = 31;
  localparam int PKT_PC_LSB      = 32;
  localparam int PKT_PC_MSB      = 63;
  localparam int PKT_PC_NEXT_LSB = 64;
  localparam int PKT_PC_NEXT_MSB = 95;
  localparam int PKT_EXCP_LSB    = 96;
  localparam int PKT_EXCP_MSB    = 102;

  // Slot1 alone (2'b10) is a fetch protocol error and contributes nothing.
  function automatic logic [1:0] push_count(input logic [1:0] vld);
    logic [1:0] n;
    case (vld)
      2'b01:   n = 2'd1;
      2'b11:   n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ibuf_regfile.sv
// Instruction buffer storage: two write ports, two asynchronous read ports, no reset.
module ibuf_regfile
  import decode_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PKT_W = FETCH_PKT_W,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [PTR_W-1:0] wa0,
  input  logic [PKT_W-1:0] wd0,
  input  logic             we1,
  input  logic [PTR_W-1:0] wa1,
  input  logic [PKT_W-1:0] wd1,
  input  logic [PTR_W-1:0] ra0,
  input  logic [PTR_W-1:0] ra1,
  output logic [PKT_W-1:0] rd0,
  output logic [PKT_W-1:0] rd1
);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];

  // Write addresses are always consecutive, so the two ports never collide.
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[wa0] = wd0;
    if (we1) mem_d[wa1] = wd1;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd0 = mem_q[ra0];
  assign rd1 = mem_q[ra1];

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage instruction buffer: queues up to two fetch packets per cycle and
// issues one or two of the oldest to the decoders, honouring single-issue feedback.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PKT_W = FETCH_PKT_W,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [1:0]         in_valid,
  input  logic [2*PKT_W-1:0] in_pkt,
  output logic               in_ready,
  output logic [1:0]         out_valid,
  output logic [2*PKT_W-1:0] out_pkt,
  input  logic [1:0]         dec_single,
  input  logic               out_ready,
  output logic [PTR_W:0]     count
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ROOM = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_en, pop_en;
  logic             v0, v1;
  logic             we0, we1;
  logic [1:0]       n_push, n_pop;
  logic [PKT_W-1:0] head0, head1;

  // Room is judged from registered occupancy only, so fetch never waits on out_ready.
  assign in_ready = (cnt_q <= CNT_ROOM);

  always_comb begin
    v0 = (cnt_q != '0) && !flush;
    v1 = v0 && (cnt_q >= CNT_W'(2)) && !dec_single[0] && !dec_single[1];
  end

  assign out_valid = {v1, v0};

  assign push_en = in_ready && !flush;
  assign pop_en  = out_ready && !flush;
  assign we0     = push_en && in_valid[0];
  assign we1     = push_en && (in_valid == 2'b11);
  assign n_push  = push_en ? push_count(in_valid) : 2'd0;
  assign n_pop   = !pop_en ? 2'd0 : v1 ? 2'd2 : v0 ? 2'd1 : 2'd0;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    cnt_d    = cnt_q + CNT_W'(n_push) - CNT_W'(n_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  ibuf_regfile #(
    .DEPTH (DEPTH),
    .PKT_W (PKT_W),
    .PTR_W (PTR_W)
  ) u_ibuf_regfile (
    .clk (clk),
    .we0 (we0),
    .wa0 (wr_ptr_q),
    .wd0 (in_pkt[PKT_W-1:0]),
    .we1 (we1),
    .wa1 (wr_ptr_q + PTR_W'(1)),
    .wd1 (in_pkt[2*PKT_W-1:PKT_W]),
    .ra0 (rd_ptr_q),
    .ra1 (rd_ptr_q + PTR_W'(1)),
    .rd0 (head0),
    .rd1 (head1)
  );

  assign out_pkt = {head1, head0};
  assign count   = cnt_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_MAX);
  a_grp_order: assert property (@(posedge clk) disable iff (rst) out_valid[1] |-> out_valid[0]);
  a_in_valid:  assert property (@(posedge clk) disable iff (rst) in_valid != 2'b10)
    else $warning("in_valid=2'b10 protocol violation, slot1 packet ignored");

endmodule
